// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// pipe_ctrl_pkg : shared stall indices, state encodings and default addresses
// Rev 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam int c_stall_w   = 6;
    localparam int c_stall_pc  = 0;
    localparam int c_stall_if  = 1;
    localparam int c_stall_id  = 2;
    localparam int c_stall_ex  = 3;
    localparam int c_stall_mem = 4;
    localparam int c_stall_wb  = 5;

    localparam logic [c_stall_w-1:0] c_stall_none     = 6'b000000;
    localparam logic [c_stall_w-1:0] c_stall_by_ex    = 6'b001111;
    localparam logic [c_stall_w-1:0] c_stall_by_id    = 6'b000111;
    localparam logic [c_stall_w-1:0] c_stall_by_fetch = 6'b000011;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_WAIT     = 2'd2,
        ST_REDIRECT = 2'd3
    } state_e;

    localparam logic c_chip_enable  = 1'b1;
    localparam logic c_chip_disable = 1'b0;

    localparam logic [31:0] c_default_reset_pc   = 32'h0000_0000;
    localparam logic [31:0] c_default_exc_vector = 32'h0000_0020;

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_fetch_timer.sv
// ============================================================================
// fetch_timer : loadable up-counter with terminal-count flag (fetch timeout)
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_timer #(
    parameter int TERMINAL = 15,
    parameter int CNT_W    = $clog2(TERMINAL + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_inc,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_count;

    // Any cycle that neither loads nor counts returns the timer to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end else begin
            r_count <= '0;
        end
    end

    assign o_tc = (r_count == CNT_W'(TERMINAL));

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : PC enable, stall vector, flush and redirect sequencing for the
// five-stage pipeline. Optional perf counters under PIPE_CTRL_PERF_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(c_default_reset_pc),
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(c_default_exc_vector),
    parameter int                TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              excp_valid,
    input  logic              eret_valid,
    input  logic [ADDR_W-1:0] epc,
    input  logic              imem_ack,
    output logic              imem_req,
    output logic              pc_ce,
    output logic [5:0]        stall,
    output logic              flush,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_load_addr,
    output logic              fetch_err
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [15:0]       redirect_count
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e              r_state;
    logic                r_pc_load;
    logic                r_flush;
    logic                r_fetch_err;
    logic [ADDR_W-1:0]   r_pc_load_addr;

    logic                w_in_fetch;
    logic                w_in_wait;
    logic                w_active;
    logic [5:0]          w_stall;
    logic                w_take_exc;
    logic                w_take_eret;
    logic                w_take_br;
    logic                w_redirect_req;
    logic                w_timeout;
    logic                w_enter_redirect;
    logic [ADDR_W-1:0]   w_target;
    logic                w_timer_load;
    logic                w_timer_inc;
    logic                w_timer_tc;

    assign w_in_fetch = (r_state == ST_FETCH);
    assign w_in_wait  = (r_state == ST_WAIT);
    assign w_active   = w_in_fetch | w_in_wait;

    always_comb begin
        w_stall = c_stall_none;
        if (!w_active) begin
            w_stall = c_stall_none;
        end else if (stallreq_ex) begin
            w_stall = c_stall_by_ex;
        end else if (stallreq_id) begin
            w_stall = c_stall_by_id;
        end else if (w_in_wait || !imem_ack) begin
            w_stall = c_stall_by_fetch;
        end
    end

    // Branches are held off while ID is frozen; exceptions and ERETs are not.
    assign w_take_exc     = w_active & excp_valid;
    assign w_take_eret    = w_active & ~excp_valid & eret_valid;
    assign w_take_br      = w_active & ~excp_valid & ~eret_valid & branch_flag
                          & ~w_stall[c_stall_id];
    assign w_redirect_req = w_take_exc | w_take_eret | w_take_br;
    assign w_timeout      = w_in_wait & ~imem_ack & w_timer_tc & ~w_redirect_req;
    assign w_enter_redirect = w_redirect_req | w_timeout;

    always_comb begin
        w_target = EXC_VECTOR;
        if (w_take_eret) begin
            w_target = epc;
        end else if (w_take_br) begin
            w_target = branch_target;
        end
    end

    assign w_timer_load = w_in_fetch & ~imem_ack & ~w_redirect_req;
    assign w_timer_inc  = w_in_wait & ~imem_ack & ~w_enter_redirect;

    fetch_timer #(
        .TERMINAL (TIMEOUT),
        .CNT_W    (CNT_W)
    ) u_fetch_timer (
        .clk        (clk),
        .rst_n      (rst),
        .i_load     (w_timer_load),
        .i_load_val (CNT_W'(1)),
        .i_inc      (w_timer_inc),
        .o_tc       (w_timer_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_BOOT;
            r_pc_load      <= 1'b0;
            r_flush        <= 1'b0;
            r_fetch_err    <= 1'b0;
            r_pc_load_addr <= RESET_PC;
        end else begin
            r_pc_load   <= 1'b0;
            r_flush     <= 1'b0;
            r_fetch_err <= 1'b0;
            case (r_state)
                ST_BOOT: begin
                    r_state        <= ST_FETCH;
                    r_pc_load      <= 1'b1;
                    r_pc_load_addr <= RESET_PC;
                end
                ST_FETCH, ST_WAIT: begin
                    if (w_enter_redirect) begin
                        r_state        <= ST_REDIRECT;
                        r_pc_load      <= 1'b1;
                        r_pc_load_addr <= w_target;
                        r_flush        <= ~w_take_br;
                        r_fetch_err    <= w_timeout;
                    end else begin
                        r_state <= imem_ack ? ST_FETCH : ST_WAIT;
                    end
                end
                ST_REDIRECT: begin
                    r_state <= ST_FETCH;
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    assign imem_req     = w_active;
    assign pc_ce        = (r_state == ST_BOOT) ? c_chip_disable : c_chip_enable;
    assign stall        = w_stall;
    assign flush        = r_flush;
    assign pc_load      = r_pc_load;
    assign pc_load_addr = r_pc_load_addr;
    assign fetch_err    = r_fetch_err;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_redirect_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles   <= '0;
            r_redirect_count <= '0;
        end else begin
            if (w_stall[c_stall_pc] && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_enter_redirect && (r_redirect_count != '1)) begin
                r_redirect_count <= r_redirect_count + 1'b1;
            end
        end
    end

    assign stall_cycles   = r_stall_cycles;
    assign redirect_count = r_redirect_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl : directed and randomized bench for pipe_ctrl with a cycle model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

    localparam int          TMO     = 15;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC = 32'h0000_0020;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallreq_id = 1'b0;
    logic        stallreq_ex = 1'b0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = '0;
    logic        excp_valid = 1'b0;
    logic        eret_valid = 1'b0;
    logic [31:0] epc = '0;
    logic        imem_ack = 1'b1;
    logic        imem_req;
    logic        pc_ce;
    logic [5:0]  stall;
    logic        flush;
    logic        pc_load;
    logic [31:0] pc_load_addr;
    logic        fetch_err;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles;
    logic [15:0] redirect_count;
`endif

    always #5 clk = ~clk;

    pipe_ctrl #(
        .ADDR_W     (32),
        .RESET_PC   (RST_PC),
        .EXC_VECTOR (EXC_VEC),
        .TIMEOUT    (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_id   (stallreq_id),
        .stallreq_ex   (stallreq_ex),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .excp_valid    (excp_valid),
        .eret_valid    (eret_valid),
        .epc           (epc),
        .imem_ack      (imem_ack),
        .imem_req      (imem_req),
        .pc_ce         (pc_ce),
        .stall         (stall),
        .flush         (flush),
        .pc_load       (pc_load),
        .pc_load_addr  (pc_load_addr),
        .fetch_err     (fetch_err)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles  (stall_cycles),
        .redirect_count(redirect_count)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: "booting", "redirecting" and a count of cycles spent
    // waiting on the current fetch (0 when no fetch is pending).
    bit          m_boot;
    bit          m_redir;
    int          m_wait;
    bit          m_load;
    bit          m_flush;
    bit          m_err;
    logic [31:0] m_addr;
    longint      m_stall_cyc;
    int          m_redir_cnt;

    task automatic model_reset();
        m_boot = 1; m_redir = 0; m_wait = 0;
        m_load = 0; m_flush = 0; m_err = 0; m_addr = RST_PC;
        m_stall_cyc = 0; m_redir_cnt = 0;
    endtask

    function automatic logic [5:0] exp_stall();
        if (m_boot || m_redir)              return 6'b000000;
        if (stallreq_ex)                    return 6'b001111;
        if (stallreq_id)                    return 6'b000111;
        if (m_wait > 0 || !imem_ack)        return 6'b000011;
        return 6'b000000;
    endfunction

    task automatic check_outputs();
        chk_eq("stall",     stall,     exp_stall());
        chk_eq("imem_req",  imem_req,  !(m_boot || m_redir));
        chk_eq("pc_ce",     pc_ce,     !m_boot);
        chk_eq("pc_load",   pc_load,   m_load);
        chk_eq("flush",     flush,     m_flush);
        chk_eq("fetch_err", fetch_err, m_err);
        if (m_load) chk_eq("pc_load_addr", pc_load_addr, m_addr);
`ifdef PIPE_CTRL_PERF_EN
        chk_eq("stall_cycles",   stall_cycles,   32'(m_stall_cyc));
        chk_eq("redirect_count", redirect_count, 32'(m_redir_cnt));
`endif
    endtask

    task automatic model_advance();
        bit          go;
        logic [31:0] tgt;
        bit          fl;
        bit          er;
        if (exp_stall() != 6'b000000) m_stall_cyc++;
        m_load = 0; m_flush = 0; m_err = 0;
        if (m_boot) begin
            m_boot = 0; m_load = 1; m_addr = RST_PC; m_wait = 0;
        end else if (m_redir) begin
            m_redir = 0; m_wait = 0;
        end else begin
            go = 1; er = 0; fl = 1; tgt = EXC_VEC;
            if (excp_valid)                                         tgt = EXC_VEC;
            else if (eret_valid)                                    tgt = epc;
            else if (branch_flag && !stallreq_ex && !stallreq_id) begin tgt = branch_target; fl = 0; end
            else if (m_wait == TMO && !imem_ack)                    er = 1;
            else                                                    go = 0;
            if (go) begin
                m_redir = 1; m_load = 1; m_addr = tgt; m_flush = fl; m_err = er;
                m_wait = 0; m_redir_cnt++;
            end else if (imem_ack) begin
                m_wait = 0;
            end else begin
                m_wait = m_wait + 1;
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic ex, input logic id, input logic br, input logic [31:0] bt,
                        input logic exc, input logic er, input logic [31:0] ep, input logic ack);
        stallreq_ex = ex; stallreq_id = id; branch_flag = br; branch_target = bt;
        excp_valid = exc; eret_valid = er; epc = ep; imem_ack = ack;
        #1;
        check_outputs();
        model_advance();
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ack);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, ack);
    endtask

    task automatic check_reset_values(input string tag);
        chk_eq({tag, "_pc_ce"},   pc_ce,        0);
        chk_eq({tag, "_req"},     imem_req,     0);
        chk_eq({tag, "_stall"},   stall,        0);
        chk_eq({tag, "_flush"},   flush,        0);
        chk_eq({tag, "_load"},    pc_load,      0);
        chk_eq({tag, "_addr"},    pc_load_addr, RST_PC);
        chk_eq({tag, "_err"},     fetch_err,    0);
    endtask

    task automatic async_reset_now(input string tag);
        #2 rst = 1'b0;
        #1 check_reset_values(tag);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int ack_low;
        model_reset();
        repeat (2) @(negedge clk);
        #1 check_reset_values("por");
        @(negedge clk);
        rst = 1'b1;

        // Boot: one cycle, then the reset PC is loaded.
        idle(1, 1);
        chk_eq("boot_load", pc_load, 1);
        chk_eq("boot_addr", pc_load_addr, 32'h0);
        idle(4, 1);

        // EX stall for three cycles.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 1);
        idle(2, 1);

        // Unstalled branch loads without a flush.
        step(0, 0, 1, 32'h100, 0, 0, 0, 1);
        chk_eq("br_load",  pc_load, 1);
        chk_eq("br_addr",  pc_load_addr, 32'h100);
        chk_eq("br_flush", flush, 0);
        idle(2, 1);

        // Branch held off by an ID stall, taken once the stall drops.
        for (int i = 0; i < 3; i++) step(0, 1, 1, 32'h200, 0, 0, 0, 1);
        step(0, 0, 1, 32'h200, 0, 0, 0, 1);
        chk_eq("br2_addr", pc_load_addr, 32'h200);
        idle(2, 1);

        // Exception beats a simultaneous branch.
        step(0, 0, 1, 32'h300, 1, 0, 0, 1);
        chk_eq("exc_flush", flush, 1);
        chk_eq("exc_addr",  pc_load_addr, 32'h20);
        idle(2, 1);

        // Fetch timeout.
        idle(20, 0);
        idle(3, 1);

        // Asynchronous reset while waiting on a fetch.
        idle(5, 0);
        async_reset_now("mid_wait");
        idle(1, 1);
        chk_eq("reboot_addr", pc_load_addr, 32'h0);
        idle(2, 1);

        ack_low = 0;
        for (int c = 0; c < 3000; c++) begin
            logic a;
            if (ack_low == 0 && $urandom_range(0, 39) == 0) ack_low = $urandom_range(1, 20);
            if (ack_low > 0) begin
                a = 1'b0;
                ack_low--;
            end else begin
                a = ($urandom_range(0, 4) != 0);
            end
            if ($urandom_range(0, 999) == 0) begin
                async_reset_now("rand_rst");
            end else begin
                step($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 6) == 0, {$urandom_range(0, 32'h3FFF), 2'b00},
                     $urandom_range(0, 32) == 0, $urandom_range(0, 32) == 0,
                     {$urandom_range(0, 32'h3FFF), 2'b00}, a);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
